// File: rtl/nbit_serial_subtractor.sv
// nbit_serial_subtractor: multi-cycle D = A - B - BI with borrow-out, CHUNK bits per cycle, LSB chunk first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output OVF.
module nbit_serial_subtractor #(
    parameter int N     = 8,
    parameter int CHUNK = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         BI,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         BO
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         OVF
`endif
);
    localparam int STEPS = N / CHUNK;
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state, w_next;
    logic [N-1:0]   r_a, r_b, r_res, w_res;
    logic           r_borrow;
    logic [CW-1:0]  r_count;
    logic [CHUNK:0] w_diff;
    logic           w_last;

    if (N < 2 || N % CHUNK != 0) begin : g_bad_cfg
        $error("nbit_serial_subtractor: need N >= 2 and N %% CHUNK == 0");
    end

    // One extra bit on the chunk difference; its MSB is the borrow into the next chunk.
    assign w_diff = {1'b0, r_a[CHUNK-1:0]} - {1'b0, r_b[CHUNK-1:0]} - (CHUNK+1)'(r_borrow);
    assign w_last = r_count == LAST;

    if (CHUNK == N) begin : g_single
        assign w_res = w_diff[CHUNK-1:0];
    end else begin : g_shift
        assign w_res = {w_diff[CHUNK-1:0], r_res[N-1:CHUNK]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = r_state == RUN;
        done = r_state == DONE;
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_sign, r_b_sign;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            D        <= '0;
            BO       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
            OVF      <= 1'b0;
`endif
        end else if (r_state == IDLE && start) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= BI;
            r_count  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_sign <= A[N-1];
            r_b_sign <= B[N-1];
`endif
        end else if (r_state == RUN) begin
            r_a      <= r_a >> CHUNK;
            r_b      <= r_b >> CHUNK;
            r_res    <= w_res;
            r_borrow <= w_diff[CHUNK];
            r_count  <= r_count + 1'b1;
            if (w_last) begin
                D  <= w_res;
                BO <= w_diff[CHUNK];
`ifdef SERIAL_SUB_OVF_EN
                OVF <= (r_a_sign != r_b_sign) && (w_res[N-1] != r_a_sign);
`endif
            end
        end
    end
endmodule
